// File: rtl/mb_pkg.sv
// Shared radix-4 modified-Booth encode/decode helpers and the iterative
// multiplier's state encoding.
package mb_pkg;

  // One Booth digit: magnitude select (one/two) and sign (neg).
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } mbe_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mbmul_state_e;

  // Encode multiplier bits {n[2k+1], n[2k], n[2k-1]} into a Booth digit.
  // 000 and 111 both give an all-zero digit, so zero rows never carry neg.
  function automatic mbe_t mbe_enc(input logic [2:0] d);
    mbe_t e;
    e.one = d[1] ^ d[0];
    e.two = (d[2] & ~d[1] & ~d[0]) | (~d[2] & d[1] & d[0]);
    e.neg = d[2] & ~(d[1] & d[0]);
    return e;
  endfunction

  // Decode one partial-product bit from multiplicand bits {m[i], m[i-1]}.
  // The +1 completing the two's-complement negation is added by the caller.
  function automatic logic mbe_dec(input mbe_t e, input logic [1:0] mb);
    return ((e.one & mb[1]) | (e.two & mb[0])) ^ e.neg;
  endfunction

endpackage

// File: rtl/mbmul_iter_mbe_row.sv
// One signed Booth partial-product row: extended multiplicand times a
// single digit in {-2,-1,0,+1,+2}.
module mbe_row
  import mb_pkg::*;
#(
  parameter int unsigned M_DW = 8
) (
  input  mbe_t              mbe_i,
  input  logic [M_DW:0]     m_i,
  output logic [M_DW+2:0]   row_o
);

  localparam int unsigned RW = M_DW + 3;

  logic [RW-1:0] m_sx;
  logic [RW-1:0] m_lo;
  logic [RW-1:0] bits;

  assign m_sx = {m_i[M_DW], m_i[M_DW], m_i};
  assign m_lo = {m_sx[RW-2:0], 1'b0};

  // Per-bit select of m or 2m, inverted when the digit is negative.
  always_comb begin
    bits = '0;
    for (int unsigned i = 0; i < RW; i++) begin
      bits[i] = mbe_dec(mbe_i, {m_sx[i], m_lo[i]});
    end
  end

  assign row_o = bits + RW'(mbe_i.neg);

endmodule

// File: rtl/mbmul_iter.sv
// Iterative radix-4 modified-Booth multiplier. Accepts one operand pair,
// folds DIGITS_PER_CYC Booth rows per busy cycle into an accumulator and
// holds the exact product until the consumer takes it.
module mbmul_iter
  import mb_pkg::*;
#(
  parameter int unsigned A_DW           = 8,
  parameter int unsigned B_DW           = 8,
  parameter int unsigned DIGITS_PER_CYC = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [A_DW-1:0]      a_i,
  input  logic [B_DW-1:0]      b_i,
  input  logic                 tc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [A_DW+B_DW-1:0] c_o
);

  localparam int unsigned C_DW  = A_DW + B_DW;
  localparam int unsigned M_DW  = (A_DW >= B_DW) ? A_DW : B_DW;
  localparam int unsigned N_DW  = (A_DW >= B_DW) ? B_DW : A_DW;
  localparam int unsigned ND    = (N_DW + 2) / 2;
  localparam int unsigned ITER  = (ND + DIGITS_PER_CYC - 1) / DIGITS_PER_CYC;
  localparam int unsigned ACC_W = C_DW + 2;
  localparam int unsigned NW    = 2 * ND + 1;
  localparam int unsigned RW    = M_DW + 3;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  mbmul_state_e state_q, state_d;

  logic [M_DW:0]      m_q, m_d;
  logic [NW-1:0]      n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   row_sum;
  logic [31:0]        dig_base;

  logic [M_DW-1:0]    m_raw;
  logic [N_DW-1:0]    n_raw;

  mbe_t               mbe [DIGITS_PER_CYC];
  logic [RW-1:0]      row [DIGITS_PER_CYC];

  // Narrower operand becomes the Booth multiplier; a wins ties.
  if (A_DW >= B_DW) begin : g_a_wide
    assign m_raw = a_i;
    assign n_raw = b_i;
  end else begin : g_b_wide
    assign m_raw = b_i;
    assign n_raw = a_i;
  end

  // The latched multiplier shifts down each busy cycle, so row j always
  // reads its digit from the same low bit window of n_q.
  for (genvar gj = 0; gj < DIGITS_PER_CYC; gj++) begin : g_row
    assign mbe[gj] = mbe_enc(n_q[2*gj+2 : 2*gj]);
    mbe_row #(.M_DW(M_DW)) u_row (
      .mbe_i (mbe[gj]),
      .m_i   (m_q),
      .row_o (row[gj])
    );
  end

  assign dig_base = 32'(cnt_q) * DIGITS_PER_CYC;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i)                   state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_W'(ITER - 1))    state_d = ST_DONE;
      ST_DONE: if (out_ready_i)                  state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes; product is the accumulator.
  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_DONE);
    c_o         = acc_q[C_DW-1:0];
  end

  // Sum this cycle's rows, each placed at weight 4^k; digits past ND are dropped.
  always_comb begin
    row_sum = '0;
    for (int unsigned j = 0; j < DIGITS_PER_CYC; j++) begin
      if (dig_base + j < ND) begin
        row_sum = row_sum + (ACC_W'($signed(row[j])) << (2 * (dig_base + j)));
      end
    end
  end

  // Datapath next state: load on accept, accumulate while busy.
  always_comb begin
    m_d   = m_q;
    n_d   = n_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (state_q == ST_IDLE && in_valid_i) begin
      m_d   = {tc_i & m_raw[M_DW-1], m_raw};
      n_d   = {{(NW - 1 - N_DW){tc_i & n_raw[N_DW-1]}}, n_raw, 1'b0};
      cnt_d = '0;
      acc_d = '0;
    end else if (state_q == ST_BUSY) begin
      acc_d = acc_q + row_sum;
      cnt_d = cnt_q + CNT_W'(1);
      n_d   = n_q >> (2 * DIGITS_PER_CYC);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_q   <= '0;
      n_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      m_q   <= m_d;
      n_q   <= n_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_mbmul_iter.sv
// Directed-vector bench for mbmul_iter: a default 8x8 instance driven from a
// table plus hand sequences, and one instance per parameter set running a
// directed product followed by random traffic against a reference multiply.
module tb_mbmul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_done = 0;

  localparam int NCFG = 5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mark_done();
    n_done++;
  endtask

  function automatic logic [63:0] ref_mul(input int aw, input int bw, input logic t,
                                          input logic [63:0] a, input logic [63:0] b);
    longint     sa, sb;
    logic [63:0] p;
    sa = longint'(a & ((64'd1 << aw) - 64'd1));
    sb = longint'(b & ((64'd1 << bw) - 64'd1));
    if (t && a[aw-1]) sa = sa - longint'(64'd1 << aw);
    if (t && b[bw-1]) sb = sb - longint'(64'd1 << bw);
    p = 64'(sa * sb);
    return p & ((64'd1 << (aw + bw)) - 64'd1);
  endfunction

  // ---------------- default 8x8 instance ----------------
  logic        rst, in_valid, in_ready, tc, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] c;

  mbmul_iter #(.A_DW(8), .B_DW(8), .DIGITS_PER_CYC(1)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .tc_i        (tc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .c_o         (c)
  );

  typedef struct {
    logic        tc;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [10];

  task automatic run_op(input logic t, input logic [7:0] va, input logic [7:0] vb,
                        output logic [15:0] prod, output int lat, output logic rdy_seen);
    tc = t; a = va; b = vb; in_valid = 1'b1; rdy_seen = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
    prod = c;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] prod;
    int          lat;
    logic        rdy_seen;
    logic        ov_seen;
    int          w;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tc = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_c", 64'(c), 64'd0);
    rst = 1'b0;

    vt[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vt[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vt[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vt[3] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81};
    vt[4] = '{1'b0, 8'h00, 8'h00, 16'h0000};
    vt[5] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
    vt[6] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vt[7] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vt[8] = '{1'b0, 8'h80, 8'h02, 16'h0100};
    vt[9] = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].tc, vt[i].a, vt[i].b, prod, lat, rdy_seen);
      chk($sformatf("vec%0d_prod", i), 64'(prod), 64'(vt[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd6);
      chk($sformatf("vec%0d_ready_low", i), 64'(rdy_seen), 64'd0);
      release_out();
      chk($sformatf("vec%0d_idle_after", i), 64'(in_ready), 64'd1);
    end

    // Back-pressure: product held for 10 cycles, new operands ignored.
    run_op(1'b1, 8'hFF, 8'h7F, prod, lat, rdy_seen);
    chk("hold_prod", 64'(prod), 64'hFF81);
    in_valid = 1'b1; a = 8'h55; b = 8'h33; tc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_c", i), 64'(c), 64'hFF81);
      chk($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d_ready", i), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    release_out();
    chk("hold_release_ready", 64'(in_ready), 64'd1);
    chk("hold_release_valid", 64'(out_valid), 64'd0);

    // Reset in the second busy cycle discards the operation.
    tc = 1'b0; a = 8'h10; b = 8'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_c", 64'(c), 64'd0);
    ov_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1'b1;
    end
    chk("midrst_no_valid", 64'(ov_seen), 64'd0);
    run_op(1'b1, 8'h85, 8'h13, prod, lat, rdy_seen);
    chk("postrst_prod", 64'(prod), 64'hF6DF);
    chk("postrst_latency", 64'(lat), 64'd6);
    release_out();

    w = 0;
    while (n_done < NCFG && w < 20000) begin
      @(posedge clk);
      w++;
    end
    chk("cfg_blocks_finished", 64'(n_done), 64'(NCFG));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // ---------------- per-parameter-set instances ----------------
  localparam int          CFG_A    [NCFG] = '{8, 12, 16, 7, 6};
  localparam int          CFG_B    [NCFG] = '{8, 8, 16, 5, 10};
  localparam int          CFG_D    [NCFG] = '{1, 2, 4, 3, 2};
  localparam int          CFG_LAT  [NCFG] = '{6, 4, 4, 2, 3};
  localparam logic        CFG_TC   [NCFG] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [63:0] CFG_DA   [NCFG] = '{64'hA5, 64'hFFF, 64'h8000, 64'h40, 64'h20};
  localparam logic [63:0] CFG_DB   [NCFG] = '{64'h5A, 64'hC8, 64'h8000, 64'h10, 64'h3FF};
  localparam logic [63:0] CFG_DEXP [NCFG] = '{64'h3A02, 64'hC7F38, 64'h40000000, 64'h400, 64'h20};

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int AW = CFG_A[g];
    localparam int BW = CFG_B[g];
    localparam int DP = CFG_D[g];

    logic            grst, gvi, gir, gtc, gov, gor;
    logic [AW-1:0]   ga;
    logic [BW-1:0]   gb;
    logic [AW+BW-1:0] gc;

    mbmul_iter #(.A_DW(AW), .B_DW(BW), .DIGITS_PER_CYC(DP)) u_dut (
      .clk_i       (clk),
      .rst_i       (grst),
      .in_valid_i  (gvi),
      .in_ready_o  (gir),
      .a_i         (ga),
      .b_i         (gb),
      .tc_i        (gtc),
      .out_valid_o (gov),
      .out_ready_i (gor),
      .c_o         (gc)
    );

    initial begin
      logic [63:0] r;
      logic [63:0] expv;
      int          lat;
      logic        hs;

      grst = 1'b1; gvi = 1'b0; gor = 1'b0; gtc = 1'b0; ga = '0; gb = '0;
      repeat (2) @(posedge clk);
      #1;
      grst = 1'b0;

      // Directed product with latency check.
      gtc = CFG_TC[g];
      r = CFG_DA[g]; ga = r[AW-1:0];
      r = CFG_DB[g]; gb = r[BW-1:0];
      gvi = 1'b1;
      @(posedge clk); #1;
      gvi = 1'b0;
      lat = 1;
      while (!gov && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("cfg%0d_latency", g), 64'(lat), 64'(CFG_LAT[g]));
      r = CFG_DEXP[g];
      chk($sformatf("cfg%0d_prod", g), 64'(gc), r);
      gor = 1'b1;
      @(posedge clk); #1;
      gor = 1'b0;
      chk($sformatf("cfg%0d_idle", g), 64'(gir), 64'd1);

      // Random back-to-back traffic with random consumer stalls.
      for (int i = 0; i < 30; i++) begin
        r = {$urandom, $urandom}; ga = r[AW-1:0];
        r = {$urandom, $urandom}; gb = r[BW-1:0];
        gtc = 1'($urandom_range(0, 1));
        expv = ref_mul(AW, BW, gtc, 64'(ga), 64'(gb));
        gvi = 1'b1;
        @(posedge clk); #1;
        hs = 1'b0;
        lat = 0;
        while (!hs && lat < 200) begin
          gvi = 1'($urandom_range(0, 1));
          ga  = ~ga;
          gor = 1'($urandom_range(0, 1));
          if (gov && gor) begin
            chk($sformatf("cfg%0d_rand%0d_prod", g, i), 64'(gc), expv);
            hs = 1'b1;
          end
          @(posedge clk); #1;
          lat++;
        end
        gvi = 1'b0;
        gor = 1'b0;
        chk($sformatf("cfg%0d_rand%0d_handshake", g, i), 64'(hs), 64'd1);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      mark_done();
    end
  end

endmodule
